// File: rtl/booth_sched_pkg.sv
// Shared types and constants for the booth_mul_sched multiplier scheduler.
// Optional build macro: BOOTH_SCHED_FIXPRI_EN (fixed-priority arbitration).
package booth_sched_pkg;

  localparam int OPW = 16;
  localparam int PW  = 2 * OPW;

  typedef logic req_id_t;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    req_id_t        id;
    logic           v;
  } s1_entry_t;

  typedef struct packed {
    logic [PW-1:0] p;
    req_id_t       id;
    logic          v;
  } s2_entry_t;

endpackage

// File: rtl/booth_wallace_cla.sv
// Combinational signed OPW x OPW multiplier: radix-4 Booth recoding,
// carry-save reduction of the partial products, final carry-propagate add.
module booth_wallace_cla
  import booth_sched_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  input  logic           cin,
  output logic [PW-1:0]  p
);

  logic [OPW:0]  b_ext;
  logic [PW-1:0] a_ext;
  logic [PW-1:0] pp;
  logic [PW-1:0] sum_s;
  logic [PW-1:0] sum_c;
  logic [PW-1:0] tmp;

  always_comb begin
    b_ext = {b, 1'b0};
    a_ext = {{(PW-OPW){a[OPW-1]}}, a};
    sum_s = '0;
    sum_c = '0;
    pp    = '0;
    tmp   = '0;
    for (int i = 0; i < OPW/2; i++) begin
      // Overlapping bit triplets select 0, +-a or +-2a for each digit.
      case (b_ext[2*i +: 3])
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext << 1;
        3'b100:         pp = -(a_ext << 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      pp    = pp << (2*i);
      tmp   = sum_s ^ sum_c ^ pp;
      sum_c = ((sum_s & sum_c) | (sum_s & pp) | (sum_c & pp)) << 1;
      sum_s = tmp;
    end
    p = sum_s + sum_c + PW'(cin);
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-input arbiter: round-robin by default, fixed priority (requester 0)
// when BOOTH_SCHED_FIXPRI_EN is defined.
module rr_arb2
  import booth_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       gnt_v,
  output req_id_t    gnt_id
);

`ifdef BOOTH_SCHED_FIXPRI_EN

  assign gnt_v  = |req;
  assign gnt_id = !req[0];

`else

  req_id_t last_q;
  req_id_t last_d;

  always_comb begin
    gnt_v = |req;
    // Under contention the requester not granted most recently wins.
    if (req[0] && req[1]) gnt_id = ~last_q;
    else                  gnt_id = req[1];
    last_d = accept ? gnt_id : last_q;
  end

  // Reset to "1 was last" so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

`endif

endmodule

// File: rtl/booth_mul_sched.sv
// Two-requester scheduler sharing one booth_wallace_cla through a two-stage
// pipeline. Optional macro: BOOTH_SCHED_FIXPRI_EN (see rr_arb2).
//
// Handshakes: a transfer happens on an edge where valid && ready are both
// high; ready may depend on valid, and a source holds valid and payload
// stable until the transfer.
module booth_mul_sched
  import booth_sched_pkg::*;
#(
  parameter int OPW = booth_sched_pkg::OPW,
  parameter int PW  = booth_sched_pkg::PW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_a,
  input  logic [OPW-1:0] req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_a,
  input  logic [OPW-1:0] req1_b,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [PW-1:0]  res_data,
  output logic           res_id,
  output logic           busy
);

  s1_entry_t     s1_q, s1_d;
  s2_entry_t     s2_q, s2_d;
  logic          en;
  logic          gnt_v;
  logic          accept;
  req_id_t       gnt_id;
  logic [PW-1:0] prod;

  assign en     = !s2_q.v || res_ready;
  assign accept = en && gnt_v && rst_n;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1_valid, req0_valid}),
    .accept (accept),
    .gnt_v  (gnt_v),
    .gnt_id (gnt_id)
  );

  booth_wallace_cla u_mul (
    .a   (s1_q.a),
    .b   (s1_q.b),
    .cin (1'b0),
    .p   (prod)
  );

  always_comb begin
    s1_d       = s1_q;
    s2_d       = s2_q;
    req0_ready = accept && (gnt_id == 1'b0);
    req1_ready = accept && (gnt_id == 1'b1);
    if (en) begin
      s2_d.v = s1_q.v;
      // Bubbles leave the last product/id on res_* untouched.
      if (s1_q.v) begin
        s2_d.p  = prod;
        s2_d.id = s1_q.id;
      end
      if (accept) begin
        s1_d.a  = gnt_id ? req1_a : req0_a;
        s1_d.b  = gnt_id ? req1_b : req0_b;
        s1_d.id = gnt_id;
        s1_d.v  = 1'b1;
      end else begin
        s1_d.v  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign res_valid = s2_q.v;
  assign res_data  = s2_q.p;
  assign res_id    = s2_q.id;
  assign busy      = s1_q.v || s2_q.v;

endmodule
